// File: rtl/an_key_sequencer_if.sv
// Command port and tone-datapath signals of the AN key sequencer.
// Signal names match the sequencer's documented port names.
interface an_key_sequencer_if;
   logic       CMD_VAL_i;
   logic       CMD_RDY_o;
   logic [7:0] CMD_CODEs_i;
   logic [2:0] CMD_LENs_i;
   logic       CMD_CH_i;
   logic       CMD_REP_i;
   logic       TONE_WRAP_i;
   logic       KEY_o;
   logic       LXR_o;
   logic       BUSY_o;
   logic       DONE_o;

   modport master (
      output CMD_VAL_i, CMD_CODEs_i, CMD_LENs_i, CMD_CH_i, CMD_REP_i, TONE_WRAP_i,
      input  CMD_RDY_o, KEY_o, LXR_o, BUSY_o, DONE_o
   );

   modport slave (
      input  CMD_VAL_i, CMD_CODEs_i, CMD_LENs_i, CMD_CH_i, CMD_REP_i, TONE_WRAP_i,
      output CMD_RDY_o, KEY_o, LXR_o, BUSY_o, DONE_o
   );
endinterface

// File: rtl/an_key_sequencer.sv
// Morse/beacon keying scheduler: expands dot/dash commands into unit-timed key
// intervals and commits key/channel changes only on tone-phase wrap pulses.
module an_key_sequencer #(
   parameter int unsigned C_CK_Fs          = 32'd135_000_000,
   parameter int unsigned C_UNIT_CKNs      = 32'd8_100_000,
   parameter int unsigned C_DASH_UNITs     = 32'd3,
   parameter int unsigned C_CHAR_GAP_UNITs = 32'd3
) (
   input  logic              CK_i,
   input  logic              XARST_i,
   an_key_sequencer_if.slave bus
);

   localparam int unsigned C_UNITS_MAX = (C_DASH_UNITs > C_CHAR_GAP_UNITs) ?
                                         C_DASH_UNITs : C_CHAR_GAP_UNITs;
   localparam int W_UCTR  = $clog2(C_UNIT_CKNs);
   localparam int W_UNITS = $clog2(C_UNITS_MAX + 32'd1);

   localparam logic [W_UCTR-1:0]  C_UCTR_LOAD = W_UCTR'(C_UNIT_CKNs - 32'd1);
   localparam logic [W_UCTR-1:0]  C_UCTR_ZERO = W_UCTR'(32'd0);
   localparam logic [W_UCTR-1:0]  C_UCTR_ONE  = W_UCTR'(32'd1);
   localparam logic [W_UNITS-1:0] C_DASH_LEN  = W_UNITS'(C_DASH_UNITs);
   localparam logic [W_UNITS-1:0] C_DOT_LEN   = W_UNITS'(32'd1);
   localparam logic [W_UNITS-1:0] C_CGAP_LEN  = W_UNITS'(C_CHAR_GAP_UNITs);
   localparam logic [W_UNITS-1:0] C_UNITS_NIL = W_UNITS'(32'd0);

   if ((C_UNIT_CKNs < 32'd2) || (C_CHAR_GAP_UNITs < 32'd1) || (C_DASH_UNITs < 32'd1) ||
       (C_CK_Fs == 32'd0)) begin : g_bad_param
      $error("an_key_sequencer: illegal timing parameters");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_GAP  = 2'd2,
      ST_CGAP = 2'd3
   } state_t;

   state_t               r_state;
   logic [W_UCTR-1:0]    r_uctr;
   logic [W_UNITS-1:0]   r_units;
   logic [2:0]           r_elem_idx;
   logic [7:0]           r_act_code;
   logic [2:0]           r_act_len;
   logic                 r_act_ch;
   logic                 r_act_rep;
   logic                 r_pnd_vld;
   logic [7:0]           r_pnd_code;
   logic [2:0]           r_pnd_len;
   logic                 r_pnd_ch;
   logic                 r_pnd_rep;
   logic                 r_cmd_rdy;
   logic                 r_key;
   logic                 r_lxr;
   logic                 r_busy;
   logic                 r_done;

   state_t               w_state_nx;
   logic                 w_tick;
   logic                 w_int_end;
   logic                 w_cgap_end;
   logic                 w_accept;
   logic                 w_take_new;
   logic                 w_take_pnd;
   logic                 w_to_pnd;
   logic                 w_pnd_vld_nx;
   logic                 w_done_nx;
   logic                 w_trans;
   logic                 w_key_req;
   logic                 w_active;
   logic [7:0]           w_nx_code;
   logic [2:0]           w_nx_idx;
   logic [W_UNITS-1:0]   w_units_load;

   assign w_tick       = (r_uctr == C_UCTR_ZERO);
   assign w_int_end    = w_tick && (r_units == C_DOT_LEN);
   assign w_cgap_end   = (r_state == ST_CGAP) && w_int_end;
   assign w_accept     = bus.CMD_VAL_i && r_cmd_rdy;
   // A new command goes straight to ACTIVE when nothing is playing or the
   // current character retires this clock with nothing queued behind it.
   assign w_take_new   = w_accept && ((r_state == ST_IDLE) || (w_cgap_end && !r_pnd_vld));
   assign w_take_pnd   = w_cgap_end && r_pnd_vld;
   assign w_to_pnd     = w_accept && !w_take_new;
   assign w_pnd_vld_nx = w_to_pnd || (r_pnd_vld && !w_take_pnd);
   assign w_done_nx    = w_cgap_end && (w_state_nx == ST_IDLE);
   assign w_trans      = (w_state_nx != r_state);

   // FSM state register
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // FSM next-state decode
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nx = ST_RUN;
            else          w_state_nx = ST_IDLE;
         end
         ST_RUN: begin
            if (!w_int_end)                    w_state_nx = ST_RUN;
            else if (r_elem_idx == r_act_len)  w_state_nx = ST_CGAP;
            else                               w_state_nx = ST_GAP;
         end
         ST_GAP: begin
            if (w_int_end) w_state_nx = ST_RUN;
            else           w_state_nx = ST_GAP;
         end
         ST_CGAP: begin
            if (!w_int_end)                               w_state_nx = ST_CGAP;
            else if (r_pnd_vld || w_accept || r_act_rep)  w_state_nx = ST_RUN;
            else                                          w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      w_key_req = 1'b0;
      w_active  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_key_req = 1'b0;
            w_active  = 1'b0;
         end
         ST_RUN: begin
            w_key_req = 1'b1;
            w_active  = 1'b1;
         end
         ST_GAP, ST_CGAP: begin
            w_key_req = 1'b0;
            w_active  = 1'b1;
         end
         default: begin
            w_key_req = 1'b0;
            w_active  = 1'b0;
         end
      endcase
   end

   // Interval length to load on entry to the next state
   always_comb begin
      w_nx_code    = r_act_code;
      w_nx_idx     = 3'd0;
      w_units_load = C_UNITS_NIL;
      if (w_take_new)      w_nx_code = bus.CMD_CODEs_i;
      else if (w_take_pnd) w_nx_code = r_pnd_code;
      else                 w_nx_code = r_act_code;
      if (r_state == ST_GAP) w_nx_idx = r_elem_idx + 3'd1;
      else                   w_nx_idx = 3'd0;
      case (w_state_nx)
         ST_RUN:  w_units_load = w_nx_code[w_nx_idx] ? C_DASH_LEN : C_DOT_LEN;
         ST_GAP:  w_units_load = C_DOT_LEN;
         ST_CGAP: w_units_load = C_CGAP_LEN;
         ST_IDLE: w_units_load = C_UNITS_NIL;
         default: w_units_load = C_UNITS_NIL;
      endcase
   end

   // Unit timer, interval unit count and element index; the timer restarts on
   // every state change so each interval is exact regardless of wrap phase
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         r_uctr     <= C_UCTR_LOAD;
         r_units    <= C_UNITS_NIL;
         r_elem_idx <= 3'd0;
      end else begin
         if (w_trans || w_tick || (r_state == ST_IDLE)) r_uctr <= C_UCTR_LOAD;
         else                                          r_uctr <= r_uctr - C_UCTR_ONE;
         if (w_trans)                            r_units <= w_units_load;
         else if (w_tick && (r_state != ST_IDLE)) r_units <= r_units - C_DOT_LEN;
         else                                    r_units <= r_units;
         if (w_trans && (w_state_nx == ST_RUN)) r_elem_idx <= w_nx_idx;
         else                                   r_elem_idx <= r_elem_idx;
      end
   end

   // ACTIVE / PENDING command slots and the registered ready flag
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         r_act_code <= 8'd0;
         r_act_len  <= 3'd0;
         r_act_ch   <= 1'b0;
         r_act_rep  <= 1'b0;
         r_pnd_vld  <= 1'b0;
         r_pnd_code <= 8'd0;
         r_pnd_len  <= 3'd0;
         r_pnd_ch   <= 1'b0;
         r_pnd_rep  <= 1'b0;
         r_cmd_rdy  <= 1'b1;
      end else begin
         if (w_take_new) begin
            r_act_code <= bus.CMD_CODEs_i;
            r_act_len  <= bus.CMD_LENs_i;
            r_act_ch   <= bus.CMD_CH_i;
            r_act_rep  <= bus.CMD_REP_i;
         end else if (w_take_pnd) begin
            r_act_code <= r_pnd_code;
            r_act_len  <= r_pnd_len;
            r_act_ch   <= r_pnd_ch;
            r_act_rep  <= r_pnd_rep;
         end
         if (w_to_pnd) begin
            r_pnd_code <= bus.CMD_CODEs_i;
            r_pnd_len  <= bus.CMD_LENs_i;
            r_pnd_ch   <= bus.CMD_CH_i;
            r_pnd_rep  <= bus.CMD_REP_i;
         end
         r_pnd_vld <= w_pnd_vld_nx;
         r_cmd_rdy <= !w_pnd_vld_nx;
      end
   end

   // Wrap-aligned commit of key and channel; the channel may only move while
   // the gate is currently closed, so it can change together with a key-on
   // edge but never while a tone is already being keyed
   always_ff @(posedge CK_i or negedge XARST_i) begin
      if (!XARST_i) begin
         r_key  <= 1'b0;
         r_lxr  <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (bus.TONE_WRAP_i) r_key <= w_key_req;
         else                 r_key <= r_key;
         if (bus.TONE_WRAP_i && !r_key && w_active) r_lxr <= r_act_ch;
         else                                       r_lxr <= r_lxr;
         r_busy <= (w_state_nx != ST_IDLE);
         r_done <= w_done_nx;
      end
   end

   assign bus.CMD_RDY_o = r_cmd_rdy;
   assign bus.KEY_o     = r_key;
   assign bus.LXR_o     = r_lxr;
   assign bus.BUSY_o    = r_busy;
   assign bus.DONE_o    = r_done;

endmodule

// File: tb/tb_an_key_sequencer.sv
// Bench for an_key_sequencer: per-cycle comparison against a timeline model,
// a table of single characters, hand-written corner sequences and random traffic.
module tb_an_key_sequencer;
   localparam int U = 16;

   typedef struct {
      logic [7:0] code;
      logic [2:0] len;
      bit         ch;
      int         exp_on;
      int         exp_busy;
      int         exp_edges;
   } vec_t;

   logic CK_i;
   logic XARST_i;
   an_key_sequencer_if bus();

   an_key_sequencer #(
      .C_CK_Fs(32'd100_000_000), .C_UNIT_CKNs(32'd16),
      .C_DASH_UNITs(32'd3), .C_CHAR_GAP_UNITs(32'd3)
   ) dut (
      .CK_i(CK_i), .XARST_i(XARST_i), .bus(bus)
   );

   initial CK_i = 1'b0;
   always #5 CK_i = ~CK_i;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int wcnt = 0;

   // reference model: character timeline addressed by offset from its start
   bit         m_busy, m_rdy, m_key, m_lxr, m_done, m_ch, m_rep;
   bit         p_vld, p_ch, p_rep;
   logic [7:0] m_code, p_code;
   logic [2:0] m_len, p_len;
   int         m_off;

   int s_on, s_edges, s_busy, s_done;
   int s_lxr_viol = 0;
   bit prev_key, prev_lxr;

   function automatic bit key_at(input logic [7:0] code, input logic [2:0] len, input int off);
      int t;
      t = off;
      for (int i = 0; i <= int'(len); i++) begin
         int on_t;
         int gap_t;
         on_t  = code[i] ? 3 * U : U;
         gap_t = (i == int'(len)) ? 3 * U : U;
         if (t < on_t) return 1'b1;
         t -= on_t;
         if (t < gap_t) return 1'b0;
         t -= gap_t;
      end
      return 1'b0;
   endfunction

   function automatic int char_len(input logic [7:0] code, input logic [2:0] len);
      int tot;
      tot = 0;
      for (int i = 0; i <= int'(len); i++) begin
         tot += code[i] ? 3 * U : U;
         tot += (i == int'(len)) ? 3 * U : U;
      end
      return tot;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic timeout(input string name, input int waited);
      n_chk++;
      $display("FAIL %s: condition not reached after %0d cycles (limit)", name, waited);
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_rdy = 1'b1; m_key = 1'b0; m_lxr = 1'b0; m_done = 1'b0;
      m_ch = 1'b0; m_rep = 1'b0; m_code = 8'd0; m_len = 3'd0; m_off = 0;
      p_vld = 1'b0; p_ch = 1'b0; p_rep = 1'b0; p_code = 8'd0; p_len = 3'd0;
      prev_key = 1'b0; prev_lxr = 1'b0;
   endtask

   task automatic clr_stats();
      s_on = 0; s_edges = 0; s_busy = 0; s_done = 0;
   endtask

   // one clock: drive inputs, compare outputs, advance the model, move to next negedge
   task automatic tick(input bit val, input logic [7:0] code, input logic [2:0] len,
                       input bit ch, input bit rep);
      logic [4:0] act_v, exp_v;
      bit acc, kr, cend, to_act, wr;
      wr = (wcnt == 3);
      bus.CMD_VAL_i = val; bus.CMD_CODEs_i = code; bus.CMD_LENs_i = len;
      bus.CMD_CH_i = ch; bus.CMD_REP_i = rep; bus.TONE_WRAP_i = wr;
      exp_v = {m_rdy, m_busy, m_done, m_key, m_lxr};
      act_v = {bus.CMD_RDY_o, bus.BUSY_o, bus.DONE_o, bus.KEY_o, bus.LXR_o};
      n_chk++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL cyc %0d rdy/busy/done/key/lxr: got %b, expected %b", cyc, act_v, exp_v);
      if (bus.KEY_o) s_on++;
      if (bus.KEY_o && !prev_key) s_edges++;
      if (bus.BUSY_o) s_busy++;
      if (bus.DONE_o) s_done++;
      if ((bus.LXR_o !== prev_lxr) && prev_key) s_lxr_viol++;
      prev_key = bus.KEY_o; prev_lxr = bus.LXR_o;

      acc = val && m_rdy;
      kr = m_busy && key_at(m_code, m_len, m_off);
      if (wr) begin
         if (!m_key && m_busy) m_lxr = m_ch;
         m_key = kr;
      end
      cend = m_busy && (m_off == char_len(m_code, m_len) - 1);
      m_done = 1'b0;
      to_act = 1'b0;
      if (!m_busy) begin
         to_act = acc;
      end else if (cend) begin
         if (p_vld) begin
            m_code = p_code; m_len = p_len; m_ch = p_ch; m_rep = p_rep;
            p_vld = 1'b0; m_off = 0;
         end else if (acc) begin
            to_act = 1'b1;
         end else if (m_rep) begin
            m_off = 0;
         end else begin
            m_busy = 1'b0; m_done = 1'b1;
         end
      end else begin
         m_off++;
      end
      if (to_act) begin
         m_busy = 1'b1; m_code = code; m_len = len; m_ch = ch; m_rep = rep; m_off = 0;
      end else if (acc) begin
         p_vld = 1'b1; p_code = code; p_len = len; p_ch = ch; p_rep = rep;
      end
      m_rdy = !p_vld;
      wcnt = (wcnt + 1) % 4;
      cyc++;
      @(posedge CK_i);
      @(negedge CK_i);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic send(input logic [7:0] code, input logic [2:0] len, input bit ch, input bit rep);
      int n;
      n = 0;
      while (!m_rdy && n < 2000) begin
         idle(1);
         n++;
      end
      if (!m_rdy) timeout("send_wait_ready", n);
      tick(1'b1, code, len, ch, rep);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n;
      n = 0;
      while ((m_busy || p_vld) && n < limit) begin
         idle(1);
         n++;
      end
      if (m_busy || p_vld) timeout(name, n);
      idle(2);
   endtask

   vec_t tbl[7];

   initial begin
      int n;
      tbl[0] = '{8'b0000_0010, 3'd1, 1'b1, 64, 128, 2};   // A
      tbl[1] = '{8'b0000_0001, 3'd1, 1'b0, 64, 128, 2};   // N
      tbl[2] = '{8'h00, 3'd0, 1'b1, 16, 64, 1};           // E
      tbl[3] = '{8'h01, 3'd0, 1'b0, 48, 96, 1};           // T
      tbl[4] = '{8'h00, 3'd2, 1'b1, 48, 128, 3};          // S
      tbl[5] = '{8'hFF, 3'd7, 1'b0, 384, 544, 8};         // eight dashes
      tbl[6] = '{8'hF2, 3'd1, 1'b1, 64, 128, 2};          // A with junk above LEN

      XARST_i = 1'b0;
      bus.CMD_VAL_i = 1'b0; bus.CMD_CODEs_i = 8'd0; bus.CMD_LENs_i = 3'd0;
      bus.CMD_CH_i = 1'b0; bus.CMD_REP_i = 1'b0; bus.TONE_WRAP_i = 1'b0;
      model_reset();
      clr_stats();
      repeat (3) @(negedge CK_i);
      check("reset_key", bus.KEY_o, 1'b0);
      check("reset_lxr", bus.LXR_o, 1'b0);
      check("reset_busy", bus.BUSY_o, 1'b0);
      check("reset_done", bus.DONE_o, 1'b0);
      check("reset_rdy", bus.CMD_RDY_o, 1'b1);
      XARST_i = 1'b1;
      idle(5);

      // single characters from idle
      for (int r = 0; r < 7; r++) begin
         clr_stats();
         send(tbl[r].code, tbl[r].len, tbl[r].ch, 1'b0);
         wait_idle($sformatf("row%0d_idle", r), 2000);
         check($sformatf("row%0d_key_on", r), s_on, tbl[r].exp_on);
         check($sformatf("row%0d_busy", r), s_busy, tbl[r].exp_busy);
         check($sformatf("row%0d_edges", r), s_edges, tbl[r].exp_edges);
         check($sformatf("row%0d_done", r), s_done, 1);
         check($sformatf("row%0d_lxr", r), bus.LXR_o, tbl[r].ch);
         idle(3);
      end

      // back-to-back A (L) then N (R) queued while A plays
      clr_stats();
      send(8'b10, 3'd1, 1'b1, 1'b0);
      idle(3);
      send(8'b01, 3'd1, 1'b0, 1'b0);
      check("pending_rdy_low", bus.CMD_RDY_o, 1'b0);
      wait_idle("b2b_idle", 2000);
      check("b2b_done", s_done, 1);
      check("b2b_busy", s_busy, 256);
      check("b2b_lxr", bus.LXR_o, 1'b0);

      // repeating A, then N takes over after the current repetition
      clr_stats();
      send(8'b10, 3'd1, 1'b1, 1'b1);
      idle(3 * 128 + 40);
      check("rep_no_done", s_done, 0);
      check("rep_min_edges", (s_edges >= 6), 1'b1);
      send(8'b01, 3'd1, 1'b0, 1'b0);
      wait_idle("rep_idle", 2000);
      check("rep_then_done", s_done, 1);

      // reset in the middle of a dash
      clr_stats();
      send(8'h01, 3'd0, 1'b1, 1'b0);
      idle(20);
      check("key_before_reset", bus.KEY_o, 1'b1);
      bus.CMD_VAL_i = 1'b0;
      bus.TONE_WRAP_i = 1'b0;
      XARST_i = 1'b0;
      #1;
      check("async_key", bus.KEY_o, 1'b0);
      check("async_busy", bus.BUSY_o, 1'b0);
      check("async_rdy", bus.CMD_RDY_o, 1'b1);
      model_reset();
      @(negedge CK_i);
      @(negedge CK_i);
      cyc += 2;
      wcnt = (wcnt + 2) % 4;
      XARST_i = 1'b1;
      idle(10);
      check("reset_no_done", s_done, 0);
      send(8'h00, 3'd0, 1'b0, 1'b0);
      wait_idle("post_reset_idle", 2000);
      check("post_reset_done", s_done, 1);

      // new command offered exactly in the last CGAP clock
      clr_stats();
      send(8'h00, 3'd0, 1'b0, 1'b0);
      n = 0;
      while (!(m_busy && (m_off == char_len(m_code, m_len) - 1)) && n < 500) begin
         idle(1);
         n++;
      end
      if (n >= 500) timeout("cgap_end_wait", n);
      tick(1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
      check("no_bubble_busy", bus.BUSY_o, 1'b1);
      wait_idle("nobubble_idle", 2000);
      check("nobubble_done", s_done, 1);
      check("nobubble_busy", s_busy, 64 + 96);

      // random traffic
      for (int k = 0; k < 40; k++) begin
         idle($urandom_range(0, 150));
         send(8'($urandom), 3'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
      end
      send(8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      wait_idle("random_idle", 5000);

      check("lxr_never_while_keyed", s_lxr_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
